btb_assoc: RTL and testbench

Parametrised set-associative branch target buffer for the fetch unit. It is the multi-way successor of the single-way BTB. Each entry holds valid, tag, branch position, branch type, target, saturating direction counter and RAS control. Fetch0 performs a registered lookup. Fetch1 writes new entries speculatively, and retire updates counters and indirect targets. Features beyond the single-way BTB: tree pseudo-LRU replacement, registered lookup, and a sequenced invalidate sweep after reset or flush.

---
 rtl/btb_assoc.sv | 270 +++++++++++++++++++++++++++
 tb/tb_btb_assoc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with tree pseudo-LRU replacement and invalidate sweep.
// Latency: lookup result registered one cycle after pc_f0_i; inserts/updates land at the next edge.
// Backpressure: none; ready_o low during the sweep, when inserts/updates are dropped and lookups miss.
module btb_assoc #(
    parameter int WAYS     = 2,
    parameter int SETS     = 256,
    parameter int IDX_LSB  = 2,
    parameter int TAG_W    = 40,
    parameter int CNT_W    = 2,
    parameter int CNT_INIT = 1,
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush_i,
    output logic             ready_o,
    input  logic [63:0]      pc_f0_i,
    input  logic             btb_we_spec_i,
    input  logic [63:0]      btb_brpc_spec_i,
    input  logic [2:0]       btb_brpos_spec_i,
    input  logic [1:0]       btb_brtyp_spec_i,
    input  logic [63:0]      btb_brtar_spec_i,
    input  logic [1:0]       btb_rasctl_i,
    input  logic             btb_we_cert_i,
    input  logic [63:0]      btb_brpc_cert_i,
    input  logic             btb_brdir_cert_i,
    input  logic [63:0]      btb_brtar_cert_i,
    output logic             btb_hit_f1_o,
    output logic [WAY_W-1:0] btb_way_f1_o,
    output logic [2:0]       btb_brpos_f1_o,
    output logic [1:0]       btb_brtyp_f1_o,
    output logic [63:0]      btb_brtar_f1_o,
    output logic             btb_brdir_f1_o,
    output logic [1:0]       btb_rasctl_f1_o
);
    localparam int IDX_W = $clog2(SETS);
    localparam int LVL   = $clog2(WAYS);
    localparam int PL_W  = (WAYS > 1) ? WAYS - 1 : 1;
    // Branch type encoding: 0 conditional, 1 unconditional direct, 2 indirect, 3 indirect return
    localparam logic [1:0]       BR_COND     = 2'd0;
    localparam logic [1:0]       BR_INDIR    = 2'd2;
    localparam logic [1:0]       BR_INDIRRET = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_NEW     = CNT_W'(CNT_INIT);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic             hit;
        logic [WAY_W-1:0] way;
        logic [2:0]       pos;
        logic [1:0]       typ;
        logic [63:0]      tar;
        logic             dir;
        logic [1:0]       ras;
    } f1_t;

    // Entry storage; only the valid bits are cleared by the sweep
    logic             vld_q  [WAYS][SETS];
    logic [TAG_W-1:0] tag_q  [WAYS][SETS];
    logic [2:0]       pos_q  [WAYS][SETS];
    logic [1:0]       typ_q  [WAYS][SETS];
    logic [63:0]      tar_q  [WAYS][SETS];
    logic [CNT_W-1:0] cnt_q  [WAYS][SETS];
    logic [1:0]       ras_q  [WAYS][SETS];
    logic [PL_W-1:0]  plru_q [SETS];

    state_t           state_q, state_d;
    logic [IDX_W-1:0] swp_q;
    logic             run;

    logic [IDX_W-1:0] lk_idx, ins_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, ins_tag, upd_tag;
    logic             lk_hit, ins_present, ins_free, upd_hit;
    logic [WAY_W-1:0] lk_way, ins_free_way, upd_way, ins_victim;
    logic             ins_do, upd_do;
    logic [CNT_W-1:0] ins_cnt, upd_cnt_old, upd_cnt_new;
    logic [1:0]       upd_typ;
    logic [63:0]      upd_tar_new;
    f1_t              f1_d, f1_q;

    // Tree walk: node bit 1 means the LRU side is the right subtree
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] bits);
        logic [PL_W-1:0] sh;
        int node;
        node = 0;
        for (int l = 0; l < LVL; l++) begin
            sh   = bits >> node;
            node = 2 * node + 1 + (sh[0] ? 1 : 0);
        end
        return WAY_W'(node - (WAYS - 1));
    endfunction

    // Point every node on the path to 'way' at the opposite subtree
    function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] bits, input logic [WAY_W-1:0] way);
        logic [PL_W-1:0] r;
        int n;
        int p;
        r = bits;
        n = int'(way) + WAYS - 1;
        for (int l = 0; l < LVL; l++) begin
            p = (n - 1) / 2;
            if (n == 2 * p + 1) r = r | (PL_W'(1) << p);
            else                r = r & ~(PL_W'(1) << p);
            n = p;
        end
        return r;
    endfunction

    assign lk_idx  = pc_f0_i[IDX_LSB +: IDX_W];
    assign lk_tag  = pc_f0_i[IDX_LSB + IDX_W +: TAG_W];
    assign ins_idx = btb_brpc_spec_i[IDX_LSB +: IDX_W];
    assign ins_tag = btb_brpc_spec_i[IDX_LSB + IDX_W +: TAG_W];
    assign upd_idx = btb_brpc_cert_i[IDX_LSB +: IDX_W];
    assign upd_tag = btb_brpc_cert_i[IDX_LSB + IDX_W +: TAG_W];

    // State register and sweep counter; reset and flush both restart the sweep at set 0
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            swp_q   <= '0;
        end else begin
            state_q <= state_d;
            if (flush_i || state_q == ST_RUN) swp_q <= '0;
            else                              swp_q <= swp_q + 1'b1;
        end
    end

    // Next state: leave INIT after the last set is cleared, return on flush
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (!flush_i && swp_q == IDX_W'(SETS - 1)) state_d = ST_RUN;
            ST_RUN:  if (flush_i) state_d = ST_INIT;
            default: state_d = ST_INIT;
        endcase
    end

    // FSM outputs: operational flag, also gated by reset for the write paths
    always_comb begin
        ready_o = (state_q == ST_RUN);
        run     = ready_o && reset_n;
    end

    // Tag compare for lookup, insert and retire; descending scan leaves the lowest free way
    always_comb begin
        lk_hit       = 1'b0;
        lk_way       = '0;
        ins_present  = 1'b0;
        ins_free     = 1'b0;
        ins_free_way = '0;
        upd_hit      = 1'b0;
        upd_way      = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vld_q[w][lk_idx] && tag_q[w][lk_idx] == lk_tag) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
            if (vld_q[w][ins_idx] && tag_q[w][ins_idx] == ins_tag) ins_present = 1'b1;
            if (!vld_q[w][ins_idx]) begin
                ins_free     = 1'b1;
                ins_free_way = WAY_W'(w);
            end
            if (vld_q[w][upd_idx] && tag_q[w][upd_idx] == upd_tag) begin
                upd_hit = 1'b1;
                upd_way = WAY_W'(w);
            end
        end
    end

    assign ins_victim  = ins_free ? ins_free_way : plru_victim(plru_q[ins_idx]);
    assign ins_do      = run && btb_we_spec_i && !ins_present;
    assign ins_cnt     = (btb_brtyp_spec_i == BR_COND) ? CNT_NEW : CNT_MAX;
    assign upd_cnt_old = cnt_q[upd_way][upd_idx];
    assign upd_typ     = typ_q[upd_way][upd_idx];
    assign upd_tar_new = (upd_typ == BR_INDIR || upd_typ == BR_INDIRRET) ? btb_brtar_cert_i
                                                                        : tar_q[upd_way][upd_idx];
    // An insert that evicts the entry being retired wins; the retire is dropped
    assign upd_do      = run && btb_we_cert_i && upd_hit &&
                         !(ins_do && ins_idx == upd_idx && ins_victim == upd_way);

    // Saturating direction counter; not-taken only decrements conditional branches
    always_comb begin
        upd_cnt_new = upd_cnt_old;
        if (btb_brdir_cert_i) begin
            if (upd_cnt_old != CNT_MAX) upd_cnt_new = upd_cnt_old + 1'b1;
        end else if (upd_typ == BR_COND && upd_cnt_old != '0) begin
            upd_cnt_new = upd_cnt_old - 1'b1;
        end
    end

    // Entry writes: sweep clears valid bits, RUN applies inserts and retire updates
    always_ff @(posedge clock) begin
        if (!run) begin
            for (int w = 0; w < WAYS; w++) vld_q[w][swp_q] <= 1'b0;
        end else begin
            if (ins_do) begin
                vld_q[ins_victim][ins_idx] <= 1'b1;
                tag_q[ins_victim][ins_idx] <= ins_tag;
                pos_q[ins_victim][ins_idx] <= btb_brpos_spec_i;
                typ_q[ins_victim][ins_idx] <= btb_brtyp_spec_i;
                tar_q[ins_victim][ins_idx] <= btb_brtar_spec_i;
                cnt_q[ins_victim][ins_idx] <= ins_cnt;
                ras_q[ins_victim][ins_idx] <= btb_rasctl_i;
            end
            if (upd_do) begin
                cnt_q[upd_way][upd_idx] <= upd_cnt_new;
                tar_q[upd_way][upd_idx] <= upd_tar_new;
            end
        end
    end

    // PLRU: lookup hit touched first, insert victim last when both hit one set
    always_ff @(posedge clock) begin
        if (!run) begin
            plru_q[swp_q] <= '0;
        end else begin
            if (lk_hit) plru_q[lk_idx] <= plru_touch(plru_q[lk_idx], lk_way);
            if (ins_do) plru_q[ins_idx] <= plru_touch((lk_hit && lk_idx == ins_idx)
                                                      ? plru_touch(plru_q[ins_idx], lk_way)
                                                      : plru_q[ins_idx], ins_victim);
        end
    end

    // f1 result: same-cycle insert, then same-cycle retire, then stored entry
    always_comb begin
        f1_d = '0;
        if (run) begin
            if (ins_do && btb_brpc_spec_i == pc_f0_i) begin
                f1_d.hit = 1'b1;
                f1_d.way = ins_victim;
                f1_d.pos = btb_brpos_spec_i;
                f1_d.typ = btb_brtyp_spec_i;
                f1_d.tar = btb_brtar_spec_i;
                f1_d.dir = ins_cnt[CNT_W-1];
                f1_d.ras = btb_rasctl_i;
            end else if (upd_do && btb_brpc_cert_i == pc_f0_i) begin
                f1_d.hit = 1'b1;
                f1_d.way = upd_way;
                f1_d.pos = pos_q[upd_way][upd_idx];
                f1_d.typ = upd_typ;
                f1_d.tar = upd_tar_new;
                f1_d.dir = upd_cnt_new[CNT_W-1];
                f1_d.ras = ras_q[upd_way][upd_idx];
            end else if (lk_hit) begin
                f1_d.hit = 1'b1;
                f1_d.way = lk_way;
                f1_d.pos = pos_q[lk_way][lk_idx];
                f1_d.typ = typ_q[lk_way][lk_idx];
                f1_d.tar = tar_q[lk_way][lk_idx];
                f1_d.dir = cnt_q[lk_way][lk_idx][CNT_W-1];
                f1_d.ras = ras_q[lk_way][lk_idx];
            end
        end
    end

    // f1 output register
    always_ff @(posedge clock) begin
        if (!reset_n) f1_q <= '0;
        else          f1_q <= f1_d;
    end

    assign btb_hit_f1_o    = f1_q.hit;
    assign btb_way_f1_o    = f1_q.way;
    assign btb_brpos_f1_o  = f1_q.pos;
    assign btb_brtyp_f1_o  = f1_q.typ;
    assign btb_brtar_f1_o  = f1_q.tar;
    assign btb_brdir_f1_o  = f1_q.dir;
    assign btb_rasctl_f1_o = f1_q.ras;
endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc with a lookup scoreboard.
// Latency: expects lookup results one clock after issue; sweeps take SETS cycles.
// Backpressure: none; ready_o is polled with a cycle budget.
module tb_btb_assoc;
    localparam logic [1:0] BR_COND   = 2'd0;
    localparam logic [1:0] BR_DIRECT = 2'd1;
    localparam logic [1:0] BR_INDIR  = 2'd2;

    typedef struct packed {
        logic        hit;
        logic        way;
        logic [2:0]  pos;
        logic [1:0]  typ;
        logic [63:0] tar;
        logic        dir;
        logic [1:0]  ras;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n, flush_i, ready_o;
    logic [63:0] pc_f0_i;
    logic        btb_we_spec_i;
    logic [63:0] btb_brpc_spec_i;
    logic [2:0]  btb_brpos_spec_i;
    logic [1:0]  btb_brtyp_spec_i;
    logic [63:0] btb_brtar_spec_i;
    logic [1:0]  btb_rasctl_i;
    logic        btb_we_cert_i;
    logic [63:0] btb_brpc_cert_i;
    logic        btb_brdir_cert_i;
    logic [63:0] btb_brtar_cert_i;
    logic        btb_hit_f1_o;
    logic        btb_way_f1_o;
    logic [2:0]  btb_brpos_f1_o;
    logic [1:0]  btb_brtyp_f1_o;
    logic [63:0] btb_brtar_f1_o;
    logic        btb_brdir_f1_o;
    logic [1:0]  btb_rasctl_f1_o;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors = 0;
    int    errors  = 0;
    int    n;
    logic  lk_vld  = 1'b0;
    logic  lk_pend = 1'b0;

    btb_assoc #(.WAYS(2), .SETS(256), .IDX_LSB(2), .TAG_W(40), .CNT_W(2), .CNT_INIT(1)) dut (
        .clock(clock), .reset_n(reset_n), .flush_i(flush_i), .ready_o(ready_o),
        .pc_f0_i(pc_f0_i),
        .btb_we_spec_i(btb_we_spec_i), .btb_brpc_spec_i(btb_brpc_spec_i),
        .btb_brpos_spec_i(btb_brpos_spec_i), .btb_brtyp_spec_i(btb_brtyp_spec_i),
        .btb_brtar_spec_i(btb_brtar_spec_i), .btb_rasctl_i(btb_rasctl_i),
        .btb_we_cert_i(btb_we_cert_i), .btb_brpc_cert_i(btb_brpc_cert_i),
        .btb_brdir_cert_i(btb_brdir_cert_i), .btb_brtar_cert_i(btb_brtar_cert_i),
        .btb_hit_f1_o(btb_hit_f1_o), .btb_way_f1_o(btb_way_f1_o),
        .btb_brpos_f1_o(btb_brpos_f1_o), .btb_brtyp_f1_o(btb_brtyp_f1_o),
        .btb_brtar_f1_o(btb_brtar_f1_o), .btb_brdir_f1_o(btb_brdir_f1_o),
        .btb_rasctl_f1_o(btb_rasctl_f1_o)
    );

    always #5 clock = ~clock;

    // A lookup issued before this edge has its result on the outputs after it
    always @(posedge clock) lk_pend <= lk_vld;

    // Monitor: pop the expected result whenever a lookup result is presented
    always @(negedge clock) begin : monitor
        exp_t  act;
        exp_t  e;
        string nm;
        if (lk_pend) begin
            act = {btb_hit_f1_o, btb_way_f1_o, btb_brpos_f1_o, btb_brtyp_f1_o,
                   btb_brtar_f1_o, btb_brdir_f1_o, btb_rasctl_f1_o};
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got hit=%0d tar=%h, want no result", act.hit, act.tar);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got hit=%0d way=%0d pos=%0d typ=%0d tar=%h dir=%0d ras=%0d, want hit=%0d way=%0d pos=%0d typ=%0d tar=%h dir=%0d ras=%0d",
                             nm, act.hit, act.way, act.pos, act.typ, act.tar, act.dir, act.ras,
                             e.hit, e.way, e.pos, e.typ, e.tar, e.dir, e.ras);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic hit, input logic way, input logic [2:0] pos,
                                input logic [1:0] typ, input logic [63:0] tar,
                                input logic dir, input logic [1:0] ras);
        exp_t e;
        e.hit = hit; e.way = way; e.pos = pos; e.typ = typ;
        e.tar = tar; e.dir = dir; e.ras = ras;
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        btb_we_spec_i = 1'b0;
        btb_we_cert_i = 1'b0;
        flush_i       = 1'b0;
        lk_vld        = 1'b0;
        pc_f0_i       = 64'h0;
    endtask

    task automatic ins(input logic [63:0] pc, input logic [2:0] pos, input logic [1:0] typ,
                       input logic [63:0] tar, input logic [1:0] ras);
        btb_we_spec_i    = 1'b1;
        btb_brpc_spec_i  = pc;
        btb_brpos_spec_i = pos;
        btb_brtyp_spec_i = typ;
        btb_brtar_spec_i = tar;
        btb_rasctl_i     = ras;
    endtask

    task automatic ret(input logic [63:0] pc, input logic dir, input logic [63:0] tar);
        btb_we_cert_i    = 1'b1;
        btb_brpc_cert_i  = pc;
        btb_brdir_cert_i = dir;
        btb_brtar_cert_i = tar;
    endtask

    task automatic lk(input logic [63:0] pc, input exp_t e, input string nm);
        pc_f0_i = pc;
        lk_vld  = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, got, want);
        end
    endtask

    initial begin
        reset_n = 1'b0; flush_i = 1'b0; pc_f0_i = 64'h0;
        btb_we_spec_i = 1'b0; btb_brpc_spec_i = 64'h0; btb_brpos_spec_i = 3'd0;
        btb_brtyp_spec_i = 2'd0; btb_brtar_spec_i = 64'h0; btb_rasctl_i = 2'd0;
        btb_we_cert_i = 1'b0; btb_brpc_cert_i = 64'h0; btb_brdir_cert_i = 1'b0;
        btb_brtar_cert_i = 64'h0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", {127'h0, ready_o}, 128'h0);
        check("rst_f1", {btb_hit_f1_o, btb_way_f1_o, btb_brpos_f1_o, btb_brtyp_f1_o,
                         btb_brtar_f1_o, btb_brdir_f1_o, btb_rasctl_f1_o}, 128'h0);
        reset_n = 1'b1;

        // 1: sweep after reset takes one cycle per set
        n = 0;
        while (ready_o !== 1'b1 && n < 1000) begin n++; step(); end
        check("reset_sweep_cycles", n, 256);
        lk(64'h1000, '0, "t1_empty_miss"); step();

        // 2: conditional entry and saturating counter
        ins(64'h1000, 3'd3, BR_COND, 64'h2000, 2'd1); step();
        lk(64'h1000, mk(1, 0, 3, BR_COND, 64'h2000, 0, 1), "t2_insert"); step();
        ret(64'h1000, 1, 64'h7777); step();
        ret(64'h1000, 1, 64'h7777); step();
        lk(64'h1000, mk(1, 0, 3, BR_COND, 64'h2000, 1, 1), "t2_two_taken"); step();
        ret(64'h1000, 1, 64'h7777); step();
        ret(64'h1000, 0, 64'h7777);
        lk(64'h1000, mk(1, 0, 3, BR_COND, 64'h2000, 1, 1), "t2_sat3_retire_bypass"); step();
        ret(64'h1000, 0, 64'h7777); step();
        lk(64'h1000, mk(1, 0, 3, BR_COND, 64'h2000, 0, 1), "t2_cnt1"); step();
        ret(64'h1000, 0, 64'h7777); step();
        ret(64'h1000, 0, 64'h7777); step();
        ret(64'h1000, 0, 64'h7777); step();
        ret(64'h1000, 1, 64'h7777); step();
        lk(64'h1000, mk(1, 0, 3, BR_COND, 64'h2000, 0, 1), "t2_sat0"); step();
        ret(64'h1000, 1, 64'h7777); step();
        lk(64'h1000, mk(1, 0, 3, BR_COND, 64'h2000, 1, 1), "t2_recount"); step();

        // 3: PLRU replacement in set 0x10
        ins(64'h8040, 3'd0, BR_COND, 64'hA000, 2'd0); step();
        ins(64'h8440, 3'd0, BR_COND, 64'hB000, 2'd0); step();
        lk(64'h8040, mk(1, 0, 0, BR_COND, 64'hA000, 0, 0), "t3_hit_a"); step();
        ins(64'h8840, 3'd0, BR_COND, 64'hC000, 2'd0); step();
        lk(64'h8440, '0, "t3_b_evicted"); step();
        lk(64'h8040, mk(1, 0, 0, BR_COND, 64'hA000, 0, 0), "t3_a_kept"); step();
        lk(64'h8840, mk(1, 1, 0, BR_COND, 64'hC000, 0, 0), "t3_c_way1"); step();
        ins(64'h8C40, 3'd4, BR_COND, 64'hD000, 2'd3);
        ret(64'h8040, 1, 64'h0); step();
        lk(64'h8040, '0, "t3_a_victim"); step();
        lk(64'h8C40, mk(1, 0, 4, BR_COND, 64'hD000, 0, 3), "t3_insert_beats_update"); step();

        // 4: insert bypass and duplicate insert
        ins(64'h4000, 3'd1, BR_COND, 64'h5000, 2'd0);
        lk(64'h4000, mk(1, 1, 1, BR_COND, 64'h5000, 0, 0), "t4_insert_bypass"); step();
        ins(64'h4000, 3'd1, BR_COND, 64'h6000, 2'd0);
        lk(64'h4000, mk(1, 1, 1, BR_COND, 64'h5000, 0, 0), "t4_dup_same_cycle"); step();
        lk(64'h4000, mk(1, 1, 1, BR_COND, 64'h5000, 0, 0), "t4_dup_kept"); step();

        // 5: indirect retarget, direct not-taken, absent retire
        ins(64'h2104, 3'd5, BR_INDIR, 64'h3000, 2'd2); step();
        lk(64'h2104, mk(1, 0, 5, BR_INDIR, 64'h3000, 1, 2), "t5_indir"); step();
        ret(64'h2104, 1, 64'h3800); step();
        lk(64'h2104, mk(1, 0, 5, BR_INDIR, 64'h3800, 1, 2), "t5_indir_retarget"); step();
        ins(64'h2208, 3'd2, BR_DIRECT, 64'h2400, 2'd0); step();
        ret(64'h2208, 0, 64'h9900); step();
        lk(64'h2208, mk(1, 0, 2, BR_DIRECT, 64'h2400, 1, 0), "t5_direct_not_taken"); step();
        ret(64'h2504, 1, 64'h7000); step();
        lk(64'h2504, '0, "t5_absent_miss"); step();
        lk(64'h2104, mk(1, 0, 5, BR_INDIR, 64'h3800, 1, 2), "t5_absent_no_change"); step();

        // 6: flush sweep, inserts dropped while sweeping
        flush_i = 1'b1; step();
        n = 0;
        while (ready_o !== 1'b1 && n < 1000) begin
            n++;
            if (n == 10) ins(64'h5000, 3'd0, BR_COND, 64'h5500, 2'd0);
            if (n == 20) lk(64'h1000, '0, "t6_lookup_in_sweep");
            step();
        end
        check("flush_sweep_cycles", n, 256);
        lk(64'h1000, '0, "t6_miss_1000"); step();
        lk(64'h4000, '0, "t6_miss_4000"); step();
        lk(64'h8840, '0, "t6_miss_8840"); step();
        lk(64'h8C40, '0, "t6_miss_8c40"); step();
        lk(64'h2104, '0, "t6_miss_2104"); step();
        lk(64'h2208, '0, "t6_miss_2208"); step();
        lk(64'h5000, '0, "t6_sweep_insert_dropped"); step();

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin n++; step(); end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
